// File: rtl/alu_operand_mux.sv
// ALU B-operand select: combinational reg/imm mux plus a registered
// debug side-path (operand copy, select copy, saturating imm-use count).
module alu_operand_mux #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Reg_Data,
    input  logic [WIDTH-1:0]     Ext_Imm,
    input  logic                 ALU_Src,
    output logic [WIDTH-1:0]     Mux_Out,
    output logic [WIDTH-1:0]     Mux_Out_q,
    output logic                 Src_q,
    output logic [CNT_WIDTH-1:0] Imm_Sel_Count
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Conditional operator keeps X/Z pass-through and ?: merge on X select.
    assign Mux_Out = ALU_Src ? Ext_Imm : Reg_Data;

    always_comb begin
        cnt_d = cnt_q;
        if (ALU_Src == 1'b1 && cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Mux_Out_q <= '0;
            Src_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            Mux_Out_q <= Mux_Out;
            Src_q     <= ALU_Src;
            cnt_q     <= cnt_d;
        end
    end

    assign Imm_Sel_Count = cnt_q;

endmodule

// File: tb/tb_alu_operand_mux.sv
// Bench for alu_operand_mux: directed plan steps plus random traffic,
// checked against a saturating-count model for 16- and 4-bit counters.
module tb_alu_operand_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] rd;
    logic [15:0] im;
    logic        src;

    logic [15:0] mo_a, mq_a, mo_b, mq_b;
    logic        sq_a, sq_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks;
    int errors;

    int          m_cnt16;
    int          m_cnt4;
    logic [15:0] m_mq;
    logic        m_sq;

    alu_operand_mux #(.WIDTH(16), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .Reg_Data(rd), .Ext_Imm(im),
        .ALU_Src(src), .Mux_Out(mo_a), .Mux_Out_q(mq_a),
        .Src_q(sq_a), .Imm_Sel_Count(cnt_a)
    );

    alu_operand_mux #(.WIDTH(16), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .Reg_Data(rd), .Ext_Imm(im),
        .ALU_Src(src), .Mux_Out(mo_b), .Mux_Out_q(mq_b),
        .Src_q(sq_b), .Imm_Sel_Count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt16 = 0;
        m_cnt4  = 0;
        m_mq    = '0;
        m_sq    = 1'b0;
    endtask

    // What one sampled edge means, in plain arithmetic.
    task automatic model_edge();
        if (rst_n) begin
            m_mq = src ? im : rd;
            m_sq = src;
            if (src) begin
                m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
                m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".mq_a"}, mq_a, m_mq);
        check({tag, ".mq_b"}, mq_b, m_mq);
        check({tag, ".sq_a"}, {15'd0, sq_a}, {15'd0, m_sq});
        check({tag, ".sq_b"}, {15'd0, sq_b}, {15'd0, m_sq});
        check({tag, ".cnt_a"}, cnt_a, 16'(m_cnt16));
        check({tag, ".cnt_b"}, {12'd0, cnt_b}, 16'(m_cnt4));
    endtask

    // Called just after a negedge: drive, check mux, take one edge.
    task automatic step(input string tag, input logic [15:0] r,
                        input logic [15:0] i, input logic s);
        logic [15:0] sel;
        rd  = r;
        im  = i;
        src = s;
        sel = s ? i : r;
        #1;
        check({tag, ".mux_a"}, mo_a, sel);
        check({tag, ".mux_b"}, mo_b, sel);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_regs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] zz;
        checks = 0;
        errors = 0;
        model_clear();
        rst_n = 1'b0;
        rd    = 16'h1234;
        im    = 16'h5678;
        src   = 1'b0;
        #1;
        check_regs("reset");

        // Combinational path while in reset.
        check("p1.reg", mo_a, 16'h1234);
        src = 1'b1;
        #1;
        check("p1.imm", mo_a, 16'h5678);

        zz  = 'z;
        rd  = zz;
        im  = 16'hFFFF;
        src = 1'b0;
        #1;
        check("z.reg", mo_a, zz);
        src = 1'b1;
        #1;
        check("z.imm", mo_a, 16'hFFFF);

        im  = 16'h5678;
        src = 1'b0;
        #5;
        src = 1'b1;
        #5;
        check("tog", mo_a, 16'h5678);

        @(negedge clk);
        for (int k = 0; k < 3; k++) step("rsthold", 16'h0A0A, 16'hBEEF, 1'b1);

        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step("rel", 16'h0A0A, 16'hBEEF, 1'b1);
        check("rel.cnt3", cnt_a, 16'd3);
        check("rel.mq", mq_a, 16'hBEEF);

        mid_reset("mid1");
        for (int k = 0; k < 8; k++)
            step("alt", 16'(16'h1000 + k), 16'(16'h2000 + k), k[0]);
        check("alt.cnt4", cnt_a, 16'd4);

        for (int k = 0; k < 20; k++) step("sat", 16'h0, 16'h7777, 1'b1);
        check("sat.b", {12'd0, cnt_b}, 16'h000F);
        check("sat.a", cnt_a, 16'd24);

        mid_reset("mid2");
        step("resume", 16'h3333, 16'h4444, 1'b1);
        check("resume.cnt", cnt_a, 16'd1);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset("rnd.rst");
            end else begin
                step("rnd", 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 2) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_mux.md
Name: alu_operand_mux

Overview:
- Selects the ALU second operand: either the register-file read data or the sign/zero-extended immediate.
- Sits between the register file / immediate extender and the ALU B input of the 16-bit single-cycle CPU.
- The select path is purely combinational so it meets the single-cycle timing.
- A clocked side-path provides a registered copy of the operand and select usage statistics for debug and trace.

Parameters:
- WIDTH, 16, operand data width in bits.
- CNT_WIDTH, 16, width of the immediate-select statistics counter.

Ports:
- clk  input  1  system clock; all registered state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Reg_Data  input  WIDTH  register-file operand.
- Ext_Imm  input  WIDTH  extended immediate operand.
- ALU_Src  input  1  operand select: 0 = Reg_Data, 1 = Ext_Imm.
- Mux_Out  output  WIDTH  combinational selected operand to the ALU.
- Mux_Out_q  output  WIDTH  Mux_Out registered on clk.
- Src_q  output  1  ALU_Src registered on clk.
- Imm_Sel_Count  output  CNT_WIDTH  number of rising edges sampled with ALU_Src = 1, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational path:
  - Mux_Out = ALU_Src ? Ext_Imm : Reg_Data, using a continuous conditional assignment.
  - Zero latency; output follows any input or select change within the same delta cycle.
  - No dependence on clk or rst_n; Mux_Out is valid even while rst_n = 0.
  - Bit-exact pass-through: Z and X bits on the selected input appear unchanged on Mux_Out (Reg_Data = 16'hZZZZ with ALU_Src = 0 gives 16'hZZZZ).
  - The unselected input never affects Mux_Out.
  - ALU_Src = X gives standard Verilog ?: merge: bits where both inputs agree pass through, all other bits are X.
  - No tristate drivers are introduced by the block itself.
- Registered path:
  - While rst_n = 0, asynchronously: Mux_Out_q = 0, Src_q = 0, Imm_Sel_Count = 0.
  - Each rising clk with rst_n = 1: Mux_Out_q <= Mux_Out, Src_q <= ALU_Src.
  - Each rising clk with rst_n = 1 and ALU_Src = 1: Imm_Sel_Count increments by 1.
  - Imm_Sel_Count saturates at all-ones and does not wrap.
  - Reset asserted mid-operation clears all registered outputs immediately without waiting for clk; counting resumes from 0 on the first rising edge after release.
  - Reset release coincident with a clock edge: that edge is ignored; the first update occurs on the next edge.
- Selection changes between clock edges (glitches) affect only Mux_Out; registered outputs reflect only the values present at the edge.

Test Plan:
- Reg_Data = 16'h1234, Ext_Imm = 16'h5678, ALU_Src = 0 -> Mux_Out = 16'h1234 within 10 ns; set ALU_Src = 1 -> Mux_Out = 16'h5678.
- Reg_Data = 16'hZZZZ, Ext_Imm = 16'hFFFF, ALU_Src = 0 -> Mux_Out === 16'hZZZZ (case-equality check); set ALU_Src = 1 -> 16'hFFFF.
- With Reg_Data = 16'hZZZZ and Ext_Imm = 16'h5678, toggle ALU_Src 0 -> 1 with 5 ns spacing -> Mux_Out = 16'h5678 5 ns after the last toggle, with no clock required.
- Hold rst_n = 0, apply ALU_Src = 1 and run clocks -> Mux_Out_q = 0, Src_q = 0, Imm_Sel_Count = 0 while Mux_Out still tracks the inputs; release reset, hold ALU_Src = 1 for 3 edges -> Imm_Sel_Count = 3, Src_q = 1, Mux_Out_q = Ext_Imm.
- With CNT_WIDTH = 4, hold ALU_Src = 1 for 20 edges -> Imm_Sel_Count = 4'hF and stays there; assert rst_n = 0 between edges -> count = 0 immediately.
- Alternate ALU_Src 0/1 on successive edges for 8 edges -> Imm_Sel_Count = 4; Mux_Out_q each cycle equals the operand selected at the preceding edge.
